// File: rtl/dcache_mem_subsystem.sv
// -----------------------------------------------------------------------------
// dcache_mem_subsystem
// Data memory path of the 8-bit single-cycle CPU. A direct-mapped, write-back,
// write-allocate cache (8 lines x 4 bytes) sits in front of a 256-byte memory
// that is organised as 64 blocks of 32 bits, each block access costing
// MEM_LATENCY cycles. The CPU is stalled through busywait on any miss.
//
// Ports
//   CLK        in   single clock, all state changes on the rising edge
//   RESET      in   synchronous active-high reset (clears cache, FSM, memory)
//   read       in   load request, held until busywait is low
//   write      in   store request, held until busywait is low (wins over read)
//   address    in   [7:5] tag, [4:2] line index, [1:0] byte offset
//   writedata  in   store byte
//   readdata   out  load byte; live on a read hit, otherwise last loaded byte
//   busywait   out  high while the current request has not completed
// -----------------------------------------------------------------------------
module dcache_mem_subsystem #(
    parameter int MEM_LATENCY = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       busywait
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_WRITE = 2'd1,
        MEM_READ  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    localparam int            CW         = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(MEM_LATENCY - 1);

    // Cache line storage
    logic [7:0]  valid_r;
    logic [7:0]  dirty_r;
    logic [2:0]  tag_r  [0:7];
    logic [31:0] data_r [0:7];

    // Backing memory and the block fetched from it
    logic [31:0] mem_r  [0:63];
    logic [31:0] fetch_r;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] count_r;
    logic [7:0]    readdata_r;

    logic [2:0] tag_s;
    logic [2:0] index_s;
    logic [4:0] bsel_s;
    logic       hit_s;
    logic       req_s;
    logic       idle_hit_s;
    logic       rd_hit_s;
    logic       wr_hit_s;
    logic       last_s;
    logic [7:0] line_byte_s;

    assign tag_s       = address[7:5];
    assign index_s     = address[4:2];
    assign bsel_s      = {address[1:0], 3'b000};
    assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign req_s       = read | write;
    assign idle_hit_s  = (state_r == IDLE) && hit_s;
    // A simultaneous read and write is handled as a store only.
    assign rd_hit_s    = read && !write && idle_hit_s;
    assign wr_hit_s    = write && idle_hit_s;
    assign last_s      = (count_r == LAST_COUNT);
    assign line_byte_s = data_r[index_s][bsel_s +: 8];
    assign busywait    = req_s && !idle_hit_s;

    // Load data: live byte on a read hit, otherwise the last byte delivered.
    always_comb begin
        readdata = readdata_r;
        if (rd_hit_s) begin
            readdata = line_byte_s;
        end else begin
            readdata = readdata_r;
        end
    end

    // Miss-handling FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s && !hit_s) begin
                    if (valid_r[index_s] && dirty_r[index_s]) begin
                        state_s = MEM_WRITE;
                    end else begin
                        state_s = MEM_READ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            MEM_WRITE: begin
                if (last_s) begin
                    state_s = MEM_READ;
                end else begin
                    state_s = MEM_WRITE;
                end
            end
            MEM_READ: begin
                if (last_s) begin
                    state_s = UPDATE;
                end else begin
                    state_s = MEM_READ;
                end
            end
            UPDATE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Memory latency counter; restarts on every state change so each memory
    // phase lasts exactly MEM_LATENCY cycles.
    always_ff @(posedge CLK) begin
        if (RESET || (state_s != state_r)) begin
            count_r <= {CW{1'b0}};
        end else if ((state_r == MEM_WRITE) || (state_r == MEM_READ)) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= {CW{1'b0}};
        end
    end

    // Backing memory: cleared on reset, victim block committed on the last
    // write-back cycle at the address formed from the old tag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 64; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if ((state_r == MEM_WRITE) && last_s) begin
            mem_r[{tag_r[index_s], index_s}] <= data_r[index_s];
        end
    end

    // Fill buffer: captures the requested block on the last read cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_r <= 32'd0;
        end else if ((state_r == MEM_READ) && last_s) begin
            fetch_r <= mem_r[{tag_s, index_s}];
        end
    end

    // Cache lines: refill in UPDATE, byte store on a write hit. A reset in
    // the middle of a miss returns to IDLE before UPDATE, so the fill is lost.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_r <= 8'd0;
            dirty_r <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                tag_r[i]  <= 3'd0;
                data_r[i] <= 32'd0;
            end
        end else if (state_r == UPDATE) begin
            data_r[index_s]  <= fetch_r;
            tag_r[index_s]   <= tag_s;
            valid_r[index_s] <= 1'b1;
            dirty_r[index_s] <= 1'b0;
        end else if (wr_hit_s) begin
            data_r[index_s][bsel_s +: 8] <= writedata;
            dirty_r[index_s]             <= 1'b1;
        end
    end

    // Last delivered load byte, held while no read hit is in progress.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            readdata_r <= 8'd0;
        end else if (rd_hit_s) begin
            readdata_r <= line_byte_s;
        end
    end

endmodule

// File: tb/tb_dcache_mem_subsystem.sv
// -----------------------------------------------------------------------------
// tb_dcache_mem_subsystem
// Directed bench for dcache_mem_subsystem with MEM_LATENCY = 5. Each request
// is held until busywait drops; the number of stalled cycles and the load
// byte are compared with hand-computed values, and cache/memory contents are
// inspected after the interesting transactions.
// -----------------------------------------------------------------------------
module tb_dcache_mem_subsystem;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       read;
    logic       write;
    logic [7:0] address;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       busywait;

    int n_checks = 0;
    int n_fails  = 0;

    int         stall;
    logic [7:0] rdata;

    dcache_mem_subsystem #(.MEM_LATENCY(5)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .busywait  (busywait)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; holds the request until busywait is low,
    // counting the cycles it was high, then lets the completing edge pass.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] wd, output int stl, output logic [7:0] rdt);
        read      = rd;
        write     = wr;
        address   = a;
        writedata = wd;
        stl       = 0;
        #1;
        while ((busywait !== 1'b0) && (stl < 60)) begin
            stl++;
            @(posedge CLK);
            #1;
        end
        rdt = readdata;
        @(posedge CLK);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = 8'h00;
        writedata = 8'h00;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;

        // Reset state
        check("rst_busywait", {31'd0, busywait}, 32'd0);
        check("rst_readdata", {24'd0, readdata}, 32'd0);
        check("rst_valid",    {24'd0, dut.valid_r}, 32'd0);
        check("rst_dirty",    {24'd0, dut.dirty_r}, 32'd0);

        // Clean miss on 0x05: 7 stall cycles, memory is zero
        access(1'b1, 1'b0, 8'h05, 8'h00, stall, rdata);
        check("rd05_stall", stall, 32'd7);
        check("rd05_data",  {24'd0, rdata}, 32'd0);
        check("rd05_valid", {31'd0, dut.valid_r[1]}, 32'd1);
        check("rd05_clean", {31'd0, dut.dirty_r[1]}, 32'd0);

        // Write hit then read hit, both without stall
        access(1'b0, 1'b1, 8'h05, 8'hAB, stall, rdata);
        check("wr05_stall", stall, 32'd0);
        check("wr05_dirty", {31'd0, dut.dirty_r[1]}, 32'd1);
        access(1'b1, 1'b0, 8'h05, 8'h00, stall, rdata);
        check("rd05b_stall", stall, 32'd0);
        check("rd05b_data",  {24'd0, rdata}, 32'h0000_00AB);
        #1;
        check("hold_readdata", {24'd0, readdata}, 32'h0000_00AB);

        // Dirty write miss on 0x25: write-back of block 1, then allocate
        access(1'b0, 1'b1, 8'h25, 8'h5C, stall, rdata);
        check("wr25_stall", stall, 32'd12);
        check("wr25_mem1",  dut.mem_r[1], 32'h0000_AB00);
        check("wr25_tag",   {29'd0, dut.tag_r[1]}, 32'd1);
        check("wr25_dirty", {31'd0, dut.dirty_r[1]}, 32'd1);

        // Dirty read miss on 0x05: evicts block 9, refetches block 1
        access(1'b1, 1'b0, 8'h05, 8'h00, stall, rdata);
        check("rd05c_stall", stall, 32'd12);
        check("rd05c_data",  {24'd0, rdata}, 32'h0000_00AB);
        check("rd05c_mem9",  dut.mem_r[9], 32'h0000_5C00);
        check("rd05c_clean", {31'd0, dut.dirty_r[1]}, 32'd0);

        // read and write together act as a store
        access(1'b1, 1'b1, 8'h06, 8'h77, stall, rdata);
        check("rw06_stall", stall, 32'd0);
        access(1'b1, 1'b0, 8'h06, 8'h00, stall, rdata);
        check("rw06_data", {24'd0, rdata}, 32'h0000_0077);

        // Fill line 0 byte by byte, then evict it with a conflicting read
        access(1'b0, 1'b1, 8'h00, 8'h11, stall, rdata);
        check("wr00_stall", stall, 32'd7);
        access(1'b0, 1'b1, 8'h01, 8'h22, stall, rdata);
        access(1'b0, 1'b1, 8'h02, 8'h33, stall, rdata);
        access(1'b0, 1'b1, 8'h03, 8'h44, stall, rdata);
        check("wr03_stall", stall, 32'd0);
        access(1'b1, 1'b0, 8'hE0, 8'h00, stall, rdata);
        check("rdE0_stall", stall, 32'd12);
        check("rdE0_data",  {24'd0, rdata}, 32'd0);
        check("rdE0_mem0",  dut.mem_r[0], 32'h4433_2211);

        // Reset in the middle of a clean miss on 0x48 (line 2)
        read    = 1'b1;
        address = 8'h48;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("mid_busy",  {31'd0, busywait}, 32'd1);
        check("mid_state", {30'd0, dut.state_r}, 32'd2);
        RESET = 1'b1;
        read  = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        check("abort_busy",  {31'd0, busywait}, 32'd0);
        check("abort_valid", {24'd0, dut.valid_r}, 32'd0);
        check("abort_mem0",  dut.mem_r[0], 32'd0);
        check("abort_rdata", {24'd0, readdata}, 32'd0);
        repeat (8) @(posedge CLK);
        #1;
        check("abort_nofill", {24'd0, dut.valid_r}, 32'd0);
        access(1'b1, 1'b0, 8'h48, 8'h00, stall, rdata);
        check("reissue_stall", stall, 32'd7);
        check("reissue_data",  {24'd0, rdata}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
